alarm_trigger: RTL and testbench

Alarm-time comparator and ringing controller, sitting directly upstream of the alarm pattern generator. Watches the BCD time-of-day from the clock counter, detects the armed alarm minute, and drives the generator's `on` input for a bounded ring period with stop and snooze handling. Runs on the 1 kHz system tick.

---
 rtl/alarm_trigger_if.sv | 39 +++
 rtl/alarm_trigger.sv | 111 +++++++++++
 tb/tb_alarm_trigger.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_trigger_if.sv
// alarm_trigger_if
//   Bundles the time-of-day, alarm setting, key and ring-status signals
//   exchanged between the alarm trigger and its surroundings.
//   master : drives enable, time, alarm and keys; observes ring status.
//   slave  : the alarm trigger itself.
//   Ports carried:
//     enable      - alarm armed (level)
//     cur_hour/min/sec - current time, packed BCD
//     alm_hour/min     - alarm time, packed BCD
//     stop_key    - single-cycle pulse, silences the alarm
//     snooze_key  - single-cycle pulse, requests snooze
//     on          - ring request to the pattern generator
//     snoozing    - high while snoozing
//     snooze_cnt  - snoozes used in the current alarm event
interface alarm_trigger_if;
  logic       enable;
  logic [7:0] cur_hour;
  logic [7:0] cur_min;
  logic [7:0] cur_sec;
  logic [7:0] alm_hour;
  logic [7:0] alm_min;
  logic       stop_key;
  logic       snooze_key;
  logic       on;
  logic       snoozing;
  logic [2:0] snooze_cnt;

  modport master (
    output enable, cur_hour, cur_min, cur_sec, alm_hour, alm_min,
           stop_key, snooze_key,
    input  on, snoozing, snooze_cnt
  );

  modport slave (
    input  enable, cur_hour, cur_min, cur_sec, alm_hour, alm_min,
           stop_key, snooze_key,
    output on, snoozing, snooze_cnt
  );
endinterface

// File: rtl/alarm_trigger.sv
// alarm_trigger
//   Compares the BCD time of day against the armed alarm time and drives the
//   ring request of the downstream pattern generator for a bounded ring
//   period, with stop and a limited number of snoozes per alarm event.
//   Ports:
//     clk1khz - 1 kHz system tick
//     rst     - synchronous, active-high reset
//     bus     - alarm_trigger_if.slave (time, alarm, keys in; on, snoozing,
//               snooze_cnt out, all outputs registered)
module alarm_trigger #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int RING_SEC      = 60,
  parameter int SNOOZE_SEC    = 300,
  parameter int MAX_SNOOZE    = 3
) (
  input  logic             clk1khz,
  input  logic             rst,
  alarm_trigger_if.slave   bus
);

  localparam logic [31:0] RING_LAST   = 32'(RING_SEC * TICKS_PER_SEC - 1);
  localparam logic [31:0] SNOOZE_LAST = 32'(SNOOZE_SEC * TICKS_PER_SEC - 1);
  localparam logic [2:0]  SNZ_MAX     = 3'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] tcnt, tcnt_nxt;
  logic [2:0]  snz_cnt, snz_nxt;
  logic        match, match_d, fire;
  logic        on_r, snoozing_r;

  // Raw byte equality; second 00 lasts a whole second, so only the rising
  // edge of the match window is allowed to start an event.
  assign match = bus.enable
               & (bus.cur_hour == bus.alm_hour)
               & (bus.cur_min  == bus.alm_min)
               & (bus.cur_sec  == 8'h00);
  assign fire  = match & ~match_d;

  always_comb begin
    state_nxt = state;
    snz_nxt   = snz_cnt;

    if (!bus.enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (fire) state_nxt = RINGING;
        end
        RINGING: begin
          if (bus.stop_key) begin
            state_nxt = IDLE;
          end else if (bus.snooze_key && (snz_cnt < SNZ_MAX)) begin
            state_nxt = SNOOZE;
            snz_nxt   = snz_cnt + 3'd1;
          end else if (tcnt == RING_LAST) begin
            state_nxt = IDLE;
          end
        end
        SNOOZE: begin
          if (bus.stop_key) begin
            state_nxt = IDLE;
          end else if (tcnt == SNOOZE_LAST) begin
            state_nxt = RINGING;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Every way back to IDLE ends the event, so the snooze budget resets.
    if (state_nxt == IDLE) snz_nxt = 3'd0;

    // The counter restarts on any state entry; it is held at zero in IDLE
    // where no timeout applies.
    if ((state_nxt != state) || (state_nxt == IDLE)) begin
      tcnt_nxt = 32'd0;
    end else begin
      tcnt_nxt = tcnt + 32'd1;
    end
  end

  always_ff @(posedge clk1khz) begin
    if (rst) begin
      state      <= IDLE;
      tcnt       <= 32'd0;
      snz_cnt    <= 3'd0;
      match_d    <= 1'b0;
      on_r       <= 1'b0;
      snoozing_r <= 1'b0;
    end else begin
      state      <= state_nxt;
      tcnt       <= tcnt_nxt;
      snz_cnt    <= snz_nxt;
      match_d    <= match;
      on_r       <= (state_nxt == RINGING);
      snoozing_r <= (state_nxt == SNOOZE);
    end
  end

  assign bus.on         = on_r;
  assign bus.snoozing   = snoozing_r;
  assign bus.snooze_cnt = snz_cnt;

endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger
//   Directed scenarios followed by a randomized run, every cycle scored
//   against a countdown-based behavioural model of the alarm event.
module tb_alarm_trigger;

  localparam int TPS    = 10;
  localparam int RSEC   = 3;
  localparam int SSEC   = 2;
  localparam int MAXS   = 2;
  localparam int RING_N = RSEC * TPS;
  localparam int SNZ_N  = SSEC * TPS;

  logic clk1khz = 1'b0;
  logic rst;
  alarm_trigger_if bus();

  alarm_trigger #(
    .TICKS_PER_SEC(TPS),
    .RING_SEC     (RSEC),
    .SNOOZE_SEC   (SSEC),
    .MAX_SNOOZE   (MAXS)
  ) dut (
    .clk1khz(clk1khz),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk1khz = ~clk1khz;

  int total = 0;
  int bad   = 0;

  // Reference: mode 0 quiet, 1 ringing, 2 snoozing; m_left counts cycles
  // remaining in the current ring or snooze period.
  int m_mode = 0;
  int m_left = 0;
  int m_snz  = 0;
  bit m_prev = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit m, f;
    if (rst) begin
      m_mode = 0; m_left = 0; m_snz = 0; m_prev = 1'b0;
      return;
    end
    m = bus.enable && (bus.cur_hour == bus.alm_hour) &&
        (bus.cur_min == bus.alm_min) && (bus.cur_sec == 8'h00);
    f = m && !m_prev;
    m_prev = m;
    if (!bus.enable) begin
      m_mode = 0; m_snz = 0;
    end else if (m_mode == 0) begin
      if (f) begin m_mode = 1; m_left = RING_N; end
    end else if (m_mode == 1) begin
      if (bus.stop_key) begin
        m_mode = 0; m_snz = 0;
      end else if (bus.snooze_key && m_snz < MAXS) begin
        m_mode = 2; m_snz++; m_left = SNZ_N;
      end else begin
        m_left--;
        if (m_left == 0) begin m_mode = 0; m_snz = 0; end
      end
    end else begin
      if (bus.stop_key) begin
        m_mode = 0; m_snz = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin m_mode = 1; m_left = RING_N; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk1khz);
    model_step();
    #1;
    chk("on",         {7'd0, bus.on},       {7'd0, m_mode == 1});
    chk("snoozing",   {7'd0, bus.snoozing}, {7'd0, m_mode == 2});
    chk("snooze_cnt", {5'd0, bus.snooze_cnt}, 8'(m_snz));
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.cur_hour = h; bus.cur_min = m; bus.cur_sec = s;
  endtask

  // Leaves the bench one sample after the alarm fires.
  task automatic fire_alarm();
    set_time(8'h07, 8'h29, 8'h59);
    tick();
    set_time(8'h07, 8'h30, 8'h00);
    tick();
    chk("fire_on", {7'd0, bus.on}, 8'd1);
  endtask

  task automatic press_snooze();
    bus.snooze_key = 1'b1; tick(); bus.snooze_key = 1'b0;
  endtask

  // Counts consecutive samples (current one included) with the chosen
  // output high; stops at limit so a stuck output cannot hang the run.
  task automatic count_high(input bit use_snz, input int limit, output int n);
    n = 0;
    while (((use_snz ? bus.snoozing : bus.on) === 1'b1) && n < limit) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rises, k;
    logic prev_on;

    rst = 1'b1;
    bus.enable = 1'b0; bus.stop_key = 1'b0; bus.snooze_key = 1'b0;
    bus.alm_hour = 8'h07; bus.alm_min = 8'h30;
    set_time(8'h07, 8'h29, 8'h59);
    tick(); tick();
    chk("rst_on",  {7'd0, bus.on}, 8'd0);
    chk("rst_snz", {5'd0, bus.snooze_cnt}, 8'd0);
    rst = 1'b0;
    tick();

    // Fire and auto-off with the time stepping at 10-cycle intervals.
    bus.enable = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("pre_fire_on", {7'd0, bus.on}, 8'd0);
    set_time(8'h07, 8'h30, 8'h00);
    n = 0; rises = 0; prev_on = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) set_time(8'h07, 8'h30, 8'h01);
      tick();
      if (i == 0) chk("latency_on", {7'd0, bus.on}, 8'd1);
      if (bus.on) n++;
      if (bus.on && !prev_on) rises++;
      prev_on = bus.on;
    end
    chk("ring_len", 8'(n), 8'(RING_N));
    chk("one_event", 8'(rises), 8'd1);

    // Stop after a random number of ring cycles; no re-fire while 07:30:00 holds.
    fire_alarm();
    k = $urandom_range(2, 20);
    for (int i = 1; i < k; i++) tick();
    bus.stop_key = 1'b1; tick(); bus.stop_key = 1'b0;
    chk("stop_on", {7'd0, bus.on}, 8'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (bus.on) n++; end
    chk("no_refire", 8'(n), 8'd0);

    // Snooze at ring cycle 10, then a full ring.
    fire_alarm();
    for (int i = 1; i < 10; i++) tick();
    press_snooze();
    chk("snz_cnt1", {5'd0, bus.snooze_cnt}, 8'd1);
    count_high(1'b1, 60, n);
    chk("snooze_len", 8'(n), 8'(SNZ_N));
    count_high(1'b0, 60, n);
    chk("ring_after_snz", 8'(n), 8'(RING_N));

    // Snooze limit: third press is ignored and the ring times out.
    fire_alarm();
    tick(); tick();
    press_snooze();
    count_high(1'b1, 60, n);
    press_snooze();
    count_high(1'b1, 60, n);
    chk("ring_again", {7'd0, bus.on}, 8'd1);
    tick(); tick(); tick();
    press_snooze();
    chk("limit_on",  {7'd0, bus.on}, 8'd1);
    chk("limit_cnt", {5'd0, bus.snooze_cnt}, 8'd2);
    count_high(1'b0, 60, n);
    chk("limit_rest", 8'(n), 8'(RING_N - 4));
    chk("limit_clr", {5'd0, bus.snooze_cnt}, 8'd0);

    // Disable during snooze.
    fire_alarm();
    press_snooze();
    tick(); tick(); tick();
    bus.enable = 1'b0; tick();
    chk("dis_on",  {7'd0, bus.on}, 8'd0);
    chk("dis_snz", {7'd0, bus.snoozing}, 8'd0);
    chk("dis_cnt", {5'd0, bus.snooze_cnt}, 8'd0);
    set_time(8'h07, 8'h30, 8'h01);
    bus.enable = 1'b1; tick();

    // Reset while ringing with snooze held.
    fire_alarm();
    tick();
    bus.snooze_key = 1'b1; rst = 1'b1; tick();
    chk("rst_mid_on",  {7'd0, bus.on}, 8'd0);
    chk("rst_mid_snz", {7'd0, bus.snoozing}, 8'd0);
    chk("rst_mid_cnt", {5'd0, bus.snooze_cnt}, 8'd0);
    bus.snooze_key = 1'b0; rst = 1'b0;
    set_time(8'h07, 8'h30, 8'h01);
    tick();

    // No match: disabled at the alarm time, then a different alarm minute.
    bus.enable = 1'b0;
    set_time(8'h07, 8'h29, 8'h59); tick();
    set_time(8'h07, 8'h30, 8'h00);
    n = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (bus.on) n++; end
    chk("nomatch_dis", 8'(n), 8'd0);
    bus.enable = 1'b1; bus.alm_min = 8'h31;
    set_time(8'h07, 8'h29, 8'h59); tick();
    set_time(8'h07, 8'h30, 8'h00);
    n = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (bus.on) n++; end
    chk("nomatch_min", 8'(n), 8'd0);
    bus.alm_min = 8'h30;

    // Randomized run scored by the per-cycle model.
    for (int i = 0; i < 600; i++) begin
      if (i % 8 == 0) begin
        case ($urandom_range(0, 2))
          0:       set_time(8'h07, 8'h29, 8'h59);
          1:       set_time(8'h07, 8'h30, 8'h00);
          default: set_time(8'h07, 8'h30, 8'h01);
        endcase
      end
      bus.enable     = ($urandom_range(0, 19) != 0);
      bus.stop_key   = ($urandom_range(0, 39) == 0);
      bus.snooze_key = ($urandom_range(0, 9) == 0);
      rst            = ($urandom_range(0, 149) == 0);
      tick();
    end
    bus.stop_key = 1'b0; bus.snooze_key = 1'b0; rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
